// File: rtl/rs232_txb_cfg_pkg.sv
// rtl/rs232_txb_cfg_pkg.sv - shared FSM encodings and bit-period helper for rs232_txb_cfg
package rs232_txb_cfg_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    function automatic int bit_cycles(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/rs232_txb_cfg_fifo.sv
// rtl/rs232_txb_cfg_fifo.sv - synchronous fifo with fill count, any depth >= 2
module rs232_txb_cfg_fifo #(
    parameter int num_slots = 63,
    parameter int width     = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic [width-1:0]               wr_data,
    input  logic                           pop,
    output logic [width-1:0]               rd_data,
    output logic                           empty,
    output logic                           full,
    output logic [$clog2(num_slots+1)-1:0] count
);
    localparam int CW = $clog2(num_slots + 1);
    localparam int PW = $clog2(num_slots);

    logic [width-1:0] mem [num_slots];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push while full is dropped even when a pop frees a slot this cycle.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign empty   = (count == '0);
    assign full    = (count == CW'(num_slots));
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PW'(num_slots - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PW'(num_slots - 1)) ? '0 : rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rs232_txb_cfg.sv
// rtl/rs232_txb_cfg.sv - buffered RS232 transmitter with run-time rate, parity and stop config
module rs232_txb_cfg
    import rs232_txb_cfg_pkg::*;
#(
    parameter int clock_freq = 50000000,
    parameter int baud_slow  = 19200,
    parameter int baud_fast  = 115200,
    parameter int num_slots  = 63,
    parameter int data_bits  = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           fsel,
    input  logic                           par_en,
    input  logic                           par_odd,
    input  logic                           stop2,
    input  logic                           wr,
    input  logic [7:0]                     data_in,
    output logic                           empty,
    output logic                           full,
    output logic [$clog2(num_slots+1)-1:0] count,
    output logic                           busy,
    output logic                           txd
);
    localparam int PER_FAST = bit_cycles(clock_freq, baud_fast);
    localparam int PER_SLOW = bit_cycles(clock_freq, baud_slow);
    localparam int PER_MAX  = (PER_FAST > PER_SLOW) ? PER_FAST : PER_SLOW;
    localparam int TW       = $clog2(PER_MAX + 1);
    localparam logic [7:0] DMASK = 8'hFF >> (8 - data_bits);

    logic [2:0]    state;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic          stop_idx;
    logic [7:0]    shift;
    logic          fsel_q;
    logic          par_en_q;
    logic          par_bit_q;
    logic          stop2_q;
    logic          txd_q;
    logic          txd_next;
    logic [7:0]    fifo_out;
    logic          bit_end;
    logic          last_stop;
    logic          load;

    rs232_txb_cfg_fifo #(
        .num_slots (num_slots),
        .width     (8)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (wr),
        .wr_data (data_in),
        .pop     (load),
        .rd_data (fifo_out),
        .empty   (empty),
        .full    (full),
        .count   (count)
    );

    assign bit_end   = (timer == (fsel_q ? TW'(PER_FAST - 1) : TW'(PER_SLOW - 1)));
    assign last_stop = (state == ST_STOP) && bit_end && (stop_idx == stop2_q);
    // Loading straight out of the final stop bit keeps back-to-back frames gapless.
    assign load      = ~empty && ((state == ST_IDLE) || last_stop);
    assign busy      = ~empty | (state != ST_IDLE);
    assign txd       = txd_q;

    always_comb begin
        txd_next = 1'b1;
        case (state)
            ST_START:  txd_next = 1'b0;
            ST_DATA:   txd_next = shift[0];
            ST_PARITY: txd_next = par_bit_q;
            default:   txd_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            timer     <= '0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
            shift     <= '0;
            fsel_q    <= 1'b0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            txd_q     <= 1'b1;
        end else begin
            txd_q <= txd_next;
            if (load) begin
                state     <= ST_START;
                timer     <= '0;
                bit_idx   <= '0;
                stop_idx  <= 1'b0;
                shift     <= fifo_out & DMASK;
                fsel_q    <= fsel;
                par_en_q  <= par_en;
                par_bit_q <= (^(fifo_out & DMASK)) ^ par_odd;
                stop2_q   <= stop2;
            end else if (state != ST_IDLE) begin
                if (bit_end) begin
                    timer <= '0;
                    case (state)
                        ST_START: begin
                            state   <= ST_DATA;
                            bit_idx <= '0;
                        end
                        ST_DATA: begin
                            shift <= shift >> 1;
                            if (bit_idx == 3'(data_bits - 1)) begin
                                state    <= par_en_q ? ST_PARITY : ST_STOP;
                                stop_idx <= 1'b0;
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                            end
                        end
                        ST_PARITY: begin
                            state    <= ST_STOP;
                            stop_idx <= 1'b0;
                        end
                        ST_STOP: begin
                            if (last_stop) begin
                                state <= ST_IDLE;
                            end else begin
                                stop_idx <= 1'b1;
                            end
                        end
                        default: state <= ST_IDLE;
                    endcase
                end else begin
                    timer <= timer + TW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_rs232_txb_cfg.sv
// tb/tb_rs232_txb_cfg.sv - directed self-checking bench for rs232_txb_cfg
module tb_rs232_txb_cfg;

    logic       clk;
    logic       rst_n;
    logic       fsel;
    logic       par_en;
    logic       par_odd;
    logic       stop2;
    logic       wr;
    logic [7:0] data_in;

    logic       empty8, full8, busy8, txd8;
    logic [2:0] count8;
    logic       empty7, full7, busy7, txd7;
    logic [2:0] count7;

    int checks = 0;
    int errors = 0;

    rs232_txb_cfg #(
        .clock_freq (1152000), .baud_slow (19200), .baud_fast (115200),
        .num_slots (4), .data_bits (8)
    ) u_dut8 (
        .clk (clk), .rst_n (rst_n), .fsel (fsel), .par_en (par_en),
        .par_odd (par_odd), .stop2 (stop2), .wr (wr), .data_in (data_in),
        .empty (empty8), .full (full8), .count (count8), .busy (busy8), .txd (txd8)
    );

    rs232_txb_cfg #(
        .clock_freq (1152000), .baud_slow (19200), .baud_fast (115200),
        .num_slots (4), .data_bits (7)
    ) u_dut7 (
        .clk (clk), .rst_n (rst_n), .fsel (fsel), .par_en (par_en),
        .par_odd (par_odd), .stop2 (stop2), .wr (wr), .data_in (data_in),
        .empty (empty7), .full (full7), .count (count7), .busy (busy7), .txd (txd7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        bit          fsel;
        bit          par_en;
        bit          par_odd;
        bit          stop2;
        bit          d7;
        int          n;
        logic [0:11] bits;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wr = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic write_byte(input logic [7:0] d);
        wr = 1'b1;
        data_in = d;
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic rx_frame(input int per, input int npar, input int nstop,
                            output logic [7:0] d, output logic pb, output bit ok);
        int t;
        ok = 1'b0;
        d = '0;
        pb = 1'b0;
        t = 0;
        while (txd8 !== 1'b0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (txd8 === 1'b0) begin
            repeat (per / 2) @(negedge clk);
            ok = (txd8 === 1'b0);
            for (int i = 0; i < 8; i++) begin
                repeat (per) @(negedge clk);
                d[i] = txd8;
            end
            if (npar != 0) begin
                repeat (per) @(negedge clk);
                pb = txd8;
            end
            for (int s = 0; s < nstop; s++) begin
                repeat (per) @(negedge clk);
                if (txd8 !== 1'b1) ok = 1'b0;
            end
        end
    endtask

    initial begin
        logic [0:29] exp3;
        logic [7:0]  rd;
        logic        pb;
        bit          ok;
        logic        tx, bz;
        int          per, len;

        vt[0] = '{8'h55, 1, 0, 0, 0, 0, 10, 12'b0_10101010_1_00};
        vt[1] = '{8'h07, 1, 1, 0, 0, 0, 11, 12'b0_11100000_1_1_0};
        vt[2] = '{8'h07, 1, 1, 1, 0, 0, 11, 12'b0_11100000_0_1_0};
        vt[3] = '{8'h07, 1, 1, 0, 1, 0, 12, 12'b0_11100000_1_11};
        vt[4] = '{8'hA3, 0, 1, 1, 0, 0, 11, 12'b0_11000101_1_1_0};
        vt[5] = '{8'hFF, 1, 0, 0, 0, 1,  9, 12'b0_1111111_1_000};
        vt[6] = '{8'hFF, 1, 1, 0, 0, 1, 10, 12'b0_1111111_1_1_00};

        rst_n = 1'b0; fsel = 1'b1; par_en = 1'b0; par_odd = 1'b0; stop2 = 1'b0;
        wr = 1'b0; data_in = 8'h00;
        @(negedge clk);
        do_reset();
        chk("rst_txd8", txd8, 1); chk("rst_empty8", empty8, 1);
        chk("rst_full8", full8, 0); chk("rst_count8", count8, 0);
        chk("rst_busy8", busy8, 0); chk("rst_txd7", txd7, 1);

        for (int v = 0; v < 7; v++) begin
            do_reset();
            fsel = vt[v].fsel; par_en = vt[v].par_en;
            par_odd = vt[v].par_odd; stop2 = vt[v].stop2;
            write_byte(vt[v].data);
            per = vt[v].fsel ? 10 : 60;
            len = vt[v].n * per;
            for (int j = 1; j <= len + 1; j++) begin
                @(negedge clk);
                tx = vt[v].d7 ? txd7 : txd8;
                bz = vt[v].d7 ? busy7 : busy8;
                if (j == 1) chk($sformatf("v%0d_pre_start", v), tx, 1);
                if (j == 2) chk($sformatf("v%0d_start_edge", v), tx, 0);
                if (j >= 2 && ((j - 2) % per) == per / 2 && ((j - 2) / per) < vt[v].n)
                    chk($sformatf("v%0d_bit%0d", v, (j - 2) / per), tx, vt[v].bits[(j - 2) / per]);
                if (j == len) chk($sformatf("v%0d_busy_hi", v), bz, 1);
                if (j == len + 1) chk($sformatf("v%0d_busy_lo", v), bz, 0);
            end
        end

        // three writes in three cycles, contiguous frames
        do_reset();
        fsel = 1'b1; par_en = 1'b0; stop2 = 1'b0;
        exp3 = {10'b0_10000000_1, 10'b0_01000000_1, 10'b0_11000000_1};
        wr = 1'b1; data_in = 8'h01;
        @(negedge clk); chk("t3_count_a", count8, 1);
        data_in = 8'h02;
        @(negedge clk); chk("t3_count_b", count8, 1);
        data_in = 8'h03;
        @(negedge clk); wr = 1'b0; chk("t3_count_c", count8, 2);
        chk("t3_start", txd8, 0);
        for (int j = 3; j <= 301; j++) begin
            @(negedge clk);
            if (((j - 2) % 10) == 5 && j < 302)
                chk($sformatf("t3_bit%0d", (j - 2) / 10), txd8, exp3[(j - 2) / 10]);
            if (j == 101 || j == 201) chk($sformatf("t3_stop_end%0d", j), txd8, 1);
            if (j == 102 || j == 202) chk($sformatf("t3_no_gap%0d", j), txd8, 0);
            if (j == 300) chk("t3_busy_hi", busy8, 1);
            if (j == 301) chk("t3_busy_lo", busy8, 0);
        end

        // overfill a 4-slot fifo while the first frame is on the line
        do_reset();
        fsel = 1'b0; par_en = 1'b0; stop2 = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            wr = 1'b1;
            data_in = 8'(i * 8'h11);
            @(negedge clk);
        end
        wr = 1'b0;
        chk("t4_full", full8, 1);
        chk("t4_count", count8, 4);
        for (int i = 1; i <= 5; i++) begin
            rx_frame(60, 0, 1, rd, pb, ok);
            chk($sformatf("t4_ok%0d", i), ok, 1);
            chk($sformatf("t4_data%0d", i), rd, 8'(i * 8'h11));
        end
        rx_frame(60, 0, 1, rd, pb, ok);
        chk("t4_sixth_dropped", ok, 0);
        chk("t4_empty", empty8, 1);

        // config change mid-frame applies to the next frame only
        do_reset();
        fsel = 1'b1; par_en = 1'b0; par_odd = 1'b0; stop2 = 1'b0;
        write_byte(8'h3C);
        write_byte(8'h5A);
        rx_frame(10, 0, 1, rd, pb, ok);
        chk("t5_f1_ok", ok, 1);
        chk("t5_f1_data", rd, 8'h3C);
        fsel = 1'b0; par_en = 1'b1;
        rx_frame(60, 1, 1, rd, pb, ok);
        chk("t5_f2_ok", ok, 1);
        chk("t5_f2_data", rd, 8'h5A);
        chk("t5_f2_parity", pb, 0);

        // reset in the middle of the data bits
        do_reset();
        fsel = 1'b1; par_en = 1'b0; stop2 = 1'b0;
        write_byte(8'h00);
        write_byte(8'h00);
        repeat (38) @(negedge clk);
        chk("t6_mid_data_low", txd8, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_txd", txd8, 1); chk("t6_count", count8, 0);
        chk("t6_busy", busy8, 0); chk("t6_empty", empty8, 1);
        rst_n = 1'b1;
        @(negedge clk);
        write_byte(8'hA5);
        rx_frame(10, 0, 1, rd, pb, ok);
        chk("t6_ok", ok, 1);
        chk("t6_data", rd, 8'hA5);
        rx_frame(10, 0, 1, rd, pb, ok);
        chk("t6_flushed", ok, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
